lfsr_checker: RTL



---
 rtl/lfsr_checker_if.sv | 36 +++
 rtl/lfsr_checker.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/lfsr_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker_if
// Description : Stream/status bundle between an LFSR word source and the
//               lfsr_checker sink.
//                 en      - din valid, sampled on the rising clock edge
//                 din     - received LFSR word (WIDTH bits)
//                 clr_cnt - synchronous clear of the error counter
//                 locked  - checker is synchronised to the stream
//                 err     - one-cycle mismatch pulse while locked
//                 err_cnt - saturating mismatch count (CNT_W bits)
//               master drives the stream, slave is the checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             en;
  logic [WIDTH-1:0] din;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output en, din, clr_cnt,
    input  locked, err, err_cnt
  );

  modport slave (
    input  en, din, clr_cnt,
    output locked, err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Receive-side LFSR word checker. Hunts for LOCK_CNT consecutive
//               correct successor words, then free-runs its own predictor and
//               flags every received word that differs from the prediction.
//               LOSS_CNT consecutive misses drop it back to hunting.
// Ports       : clk - rising-edge clock
//               rst - asynchronous active-high reset
//               bus - lfsr_checker_if.slave (en, din, clr_cnt in;
//                     locked, err, err_cnt out; all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1100,
  parameter int               LOCK_CNT = 3,
  parameter int               LOSS_CNT = 3,
  parameter int               CNT_W    = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  lfsr_checker_if.slave    bus
);

  localparam int MW  = $clog2(LOCK_CNT + 1);
  localparam int SW  = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_CNT_C = MW'(LOCK_CNT);
  localparam logic [SW-1:0] LOSS_CNT_C = SW'(LOSS_CNT);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   prev_q,      prev_d;
  logic               has_prev_q,  has_prev_d;
  logic [WIDTH-1:0]   expected_q,  expected_d;
  logic [MW-1:0]      match_cnt_q, match_cnt_d;
  logic [SW-1:0]      miss_cnt_q,  miss_cnt_d;
  logic               err_q,       err_d;
  logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;

  logic [MW-1:0]      match_inc;
  logic [SW-1:0]      miss_inc;
  logic               hunt_hit;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  assign match_inc = match_cnt_q + MW'(1);
  assign miss_inc  = miss_cnt_q + SW'(1);

  // The all-zero word is the LFSR lock-up state, so it is never accepted as
  // evidence of synchronisation even though next(0) == 0.
  assign hunt_hit = has_prev_q && (bus.din == lfsr_next(prev_q)) && (bus.din != '0);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    has_prev_d  = has_prev_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (bus.en) begin
      if (state_q == ST_HUNT) begin
        prev_d     = bus.din;
        has_prev_d = 1'b1;
        if (hunt_hit) begin
          match_cnt_d = match_inc;
          if (match_inc == LOCK_CNT_C) begin
            state_d    = ST_LOCKED;
            expected_d = lfsr_next(bus.din);
            miss_cnt_d = '0;
          end
        end else begin
          match_cnt_d = '0;
        end
      end else begin
        // Predictor advances regardless of the received word so a single
        // corrupted word costs exactly one error.
        expected_d = lfsr_next(expected_q);
        if (bus.din == expected_q) begin
          miss_cnt_d = '0;
        end else begin
          err_d      = 1'b1;
          miss_cnt_d = miss_inc;
          if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (miss_inc == LOSS_CNT_C) begin
            // Re-acquisition starts from the word that caused the loss.
            state_d     = ST_HUNT;
            match_cnt_d = '0;
            prev_d      = bus.din;
            has_prev_d  = 1'b1;
          end
        end
      end
    end

    // Clear wins over a same-edge increment; the err pulse is unaffected.
    if (bus.clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      prev_q      <= '0;
      has_prev_q  <= 1'b0;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      has_prev_q  <= has_prev_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.locked  = (state_q == ST_LOCKED);
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule
`default_nettype wire
